// File: rtl/multi_console_pkg.sv
// Shared definitions for the multi-channel console: register map, status-word
// layout and FIFO depth clamping.
package multi_console_pkg;

    typedef enum logic [1:0] {
        CONSOLE_SETUP = 2'd0,
        CONSOLE_FIFO  = 2'd1,
        CONSOLE_RXREG = 2'd2,
        CONSOLE_TXREG = 2'd3
    } console_reg_e;

    localparam int unsigned SETUP_RESET_BIT = 31;
    localparam int unsigned FIFO_RESET_BIT  = 12;
    localparam int unsigned OVF_BIT         = 12;
    localparam int unsigned EMPTY_BIT       = 8;
    localparam int unsigned BUSY_BIT        = 8;

    typedef struct packed {
        logic [3:0] lglen;
        logic [9:0] fill;
        logic       half;
        logic       avail;
    } fifo_stat_t;

    function automatic int unsigned clamp_lgflen(input int unsigned lg);
        if (lg < 2) return 2;
        if (lg > 9) return 9;
        return lg;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous character FIFO with head output, 16-bit status word and a
// sticky overflow flag; TXMODE flips the meaning of the half/avail flags.
module console_fifo
    import multi_console_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4,
    parameter bit          TXMODE = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [BW-1:0] data_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic [BW-1:0] head_o,
    output logic          empty_o,
    output fifo_stat_t    stat_o,
    output logic          ovf_o
);

    localparam int unsigned LG    = clamp_lgflen(LGFLEN);
    localparam int unsigned DEPTH = 1 << LG;
    localparam logic [LG:0] FULL_CNT = (LG+1)'(DEPTH);
    localparam logic [LG:0] HALF_CNT = (LG+1)'(DEPTH / 2);

    logic [BW-1:0] mem_q [DEPTH];
    logic [LG-1:0] wr_ptr_q, rd_ptr_q;
    logic [LG:0]   fill_q, fill_d;
    logic          half_q, half_d;
    logic          ovf_q;
    logic          full, pop_ok, push_ok;

    assign empty_o = (fill_q == '0);
    assign full    = (fill_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a push at full still lands.
    always_comb begin
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full || pop_ok);
        fill_d  = fill_q;
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        half_d = TXMODE ? (fill_d < HALF_CNT) : (fill_d >= HALF_CNT);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i)
            mem_q[wr_ptr_q] <= data_i;
    end

    // The half flag is only refreshed on a push or pop, so it reads 0 out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            half_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            fill_q <= fill_d;
            if (push_ok || pop_ok)
                half_q <= half_d;
            if (push_i && !push_ok)
                ovf_q <= 1'b1;
            else if (ovf_clr_i)
                ovf_q <= 1'b0;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign ovf_o  = ovf_q;
    assign stat_o = '{lglen: 4'(LG),
                      fill:  10'(fill_q),
                      half:  half_q,
                      avail: TXMODE ? !full : !empty_o};

endmodule

// File: rtl/multi_console.sv
// Multi-channel Wishbone console: per-channel RX/TX FIFOs, status registers
// and masked interrupts between the bus and the console byte streams.
module multi_console
    import multi_console_pkg::*;
#(
    parameter int unsigned NCHAN   = 2,
    parameter int unsigned LGNCHAN = 1,
    parameter int unsigned BW      = 8,
    parameter int unsigned LGFLEN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [LGNCHAN+1:0]    i_wb_addr,
    input  logic [31:0]           i_wb_data,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic [31:0]           o_wb_data,
    output logic [NCHAN-1:0]      o_console_stb,
    output logic [NCHAN*BW-1:0]   o_console_data,
    input  logic [NCHAN-1:0]      i_console_busy,
    input  logic [NCHAN-1:0]      i_console_stb,
    input  logic [NCHAN*BW-1:0]   i_console_data,
    output logic [NCHAN-1:0]      o_chan_int,
    output logic                  o_int
);

    localparam int unsigned AW = LGNCHAN + 2;

    logic          r_ack_q, ack_q;
    logic          req_stb_q, req_we_q;
    logic [AW-1:0] req_addr_q;
    logic [31:0]   req_data_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          int_q;

    logic [AW-1:0]    req_chan;
    console_reg_e     req_reg;
    logic [NCHAN-1:0] chan_int_d;
    logic [31:0]      chan_rdata [NCHAN];
    logic             unused_data;

    assign req_chan    = req_addr_q >> 2;
    assign req_reg     = console_reg_e'(req_addr_q[1:0]);
    assign unused_data = ^req_data_q;

    // Bus request is captured on the stb cycle and acted on one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_q    <= 1'b0;
            ack_q      <= 1'b0;
            req_stb_q  <= 1'b0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            rdata_q    <= '0;
            int_q      <= 1'b0;
        end else begin
            r_ack_q    <= i_wb_stb;
            ack_q      <= r_ack_q && i_wb_cyc;
            req_stb_q  <= i_wb_stb && i_wb_cyc;
            req_we_q   <= i_wb_we;
            req_addr_q <= i_wb_addr;
            req_data_q <= i_wb_data;
            if (req_stb_q)
                rdata_q <= rdata_d;
            int_q <= |chan_int_d;
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int unsigned c = 0; c < NCHAN; c++)
            if (req_chan == AW'(c))
                rdata_d = chan_rdata[c];
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        logic          sel, wr, setup_rst, rx_rst, tx_rst, tx_push, rx_pop, tx_pop;
        logic [3:0]    ien_q;
        logic [BW-1:0] rx_last_q;
        logic          chan_int_q;
        logic [BW-1:0] rx_head, tx_head;
        logic          rx_empty, tx_empty, rx_ovf, tx_ovf;
        fifo_stat_t    rx_stat, tx_stat;
        logic [31:0]   rword;

        assign sel       = req_stb_q && (req_chan == AW'(k));
        assign wr        = sel && req_we_q;
        assign setup_rst = wr && (req_reg == CONSOLE_SETUP) && req_data_q[SETUP_RESET_BIT];
        assign rx_rst    = i_rst || setup_rst ||
                           (wr && (req_reg == CONSOLE_RXREG) && req_data_q[FIFO_RESET_BIT]);
        assign tx_rst    = i_rst || setup_rst ||
                           (wr && (req_reg == CONSOLE_TXREG) && req_data_q[FIFO_RESET_BIT]);
        assign tx_push   = wr && (req_reg == CONSOLE_TXREG) && !req_data_q[FIFO_RESET_BIT];
        assign rx_pop    = sel && !req_we_q && (req_reg == CONSOLE_RXREG);
        assign tx_pop    = !tx_empty && !i_console_busy[k];

        console_fifo #(.BW(BW), .LGFLEN(LGFLEN), .TXMODE(1'b0)) u_rx (
            .clk_i     (i_clk),
            .rst_i     (rx_rst),
            .push_i    (i_console_stb[k]),
            .data_i    (i_console_data[k*BW +: BW]),
            .pop_i     (rx_pop),
            .ovf_clr_i (rx_pop),
            .head_o    (rx_head),
            .empty_o   (rx_empty),
            .stat_o    (rx_stat),
            .ovf_o     (rx_ovf)
        );

        console_fifo #(.BW(BW), .LGFLEN(LGFLEN), .TXMODE(1'b1)) u_tx (
            .clk_i     (i_clk),
            .rst_i     (tx_rst),
            .push_i    (tx_push),
            .data_i    (req_data_q[BW-1:0]),
            .pop_i     (tx_pop),
            .ovf_clr_i (1'b0),
            .head_o    (tx_head),
            .empty_o   (tx_empty),
            .stat_o    (tx_stat),
            .ovf_o     (tx_ovf)
        );

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                ien_q      <= '0;
                rx_last_q  <= '0;
                chan_int_q <= 1'b0;
            end else begin
                if (wr && (req_reg == CONSOLE_SETUP))
                    ien_q <= req_data_q[3:0];
                if (rx_pop && !rx_empty)
                    rx_last_q <= rx_head;
                chan_int_q <= chan_int_d[k];
            end
        end

        assign chan_int_d[k] = |(ien_q & {tx_stat.half, tx_stat.avail,
                                          rx_stat.half, rx_stat.avail});

        // An empty RX read echoes the last character actually popped.
        always_comb begin
            rword = '0;
            case (req_reg)
                CONSOLE_SETUP: rword[3:0] = ien_q;
                CONSOLE_FIFO:  rword = {tx_stat, rx_stat};
                CONSOLE_RXREG: begin
                    rword[OVF_BIT]   = rx_ovf;
                    rword[EMPTY_BIT] = rx_empty;
                    rword[BW-1:0]    = rx_empty ? rx_last_q : rx_head;
                end
                CONSOLE_TXREG: begin
                    rword[OVF_BIT]  = tx_ovf;
                    rword[BUSY_BIT] = i_console_busy[k] || !tx_empty;
                end
            endcase
        end

        assign chan_rdata[k]               = rword;
        assign o_chan_int[k]               = chan_int_q;
        assign o_console_stb[k]            = !tx_empty;
        assign o_console_data[k*BW +: BW]  = tx_head;
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_int      = int_q;

endmodule

// File: tb/tb_multi_console.sv
// Scoreboard bench for multi_console: bus reads and TX stream bytes are
// queued as expectations and checked by independent monitors.
module tb_multi_console;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic [1:0]  con_ostb, con_busy, con_istb, chan_int;
    logic [15:0] con_odata, con_idata;
    logic        irq;

    always #5 clk = ~clk;

    multi_console #(.NCHAN(2), .LGNCHAN(1), .BW(8), .LGFLEN(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wb_cyc       (wb_cyc),
        .i_wb_stb       (wb_stb),
        .i_wb_we        (wb_we),
        .i_wb_addr      (wb_addr),
        .i_wb_data      (wb_wdata),
        .o_wb_ack       (wb_ack),
        .o_wb_stall     (wb_stall),
        .o_wb_data      (wb_rdata),
        .o_console_stb  (con_ostb),
        .o_console_data (con_odata),
        .i_console_busy (con_busy),
        .i_console_stb  (con_istb),
        .i_console_data (con_idata),
        .o_chan_int     (chan_int),
        .o_int          (irq)
    );

    typedef struct {
        logic        chk;
        logic [31:0] want;
        string       name;
    } rd_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    rd_t         rdq[$];
    logic [7:0]  txq0[$];
    logic [7:0]  txq1[$];
    rd_t         mon_e;
    logic [7:0]  mon_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Bus monitor: every ack pops one scoreboard entry.
    always @(negedge clk) begin
        if (wb_ack) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h, expected no ack", wb_rdata);
            end else begin
                mon_e = rdq.pop_front();
                if (mon_e.chk)
                    check(mon_e.name, wb_rdata, mon_e.want);
            end
        end
    end

    // Stream monitor: a byte is consumed on the next edge when stb && !busy.
    always @(negedge clk) begin
        if (con_ostb[0] && !con_busy[0]) begin
            if (txq0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tx0: got byte %h, expected none", con_odata[7:0]);
            end else begin
                mon_b = txq0.pop_front();
                check("tx0_data", 32'(con_odata[7:0]), 32'(mon_b));
            end
        end
        if (con_ostb[1] && !con_busy[1]) begin
            if (txq1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tx1: got byte %h, expected none", con_odata[15:8]);
            end else begin
                mon_b = txq1.pop_front();
                check("tx1_data", 32'(con_odata[15:8]), 32'(mon_b));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wb_ack) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack, expected ack within 8 cycles");
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = data;
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
        rdq.push_back('{chk: 1'b0, want: 32'h0, name: "wr"});
        issue(1'b1, addr, data);
        wait_ack();
    endtask

    task automatic wb_read(input string name, input logic [2:0] addr, input logic [31:0] want);
        rdq.push_back('{chk: 1'b1, want: want, name: name});
        issue(1'b0, addr, 32'h0);
        wait_ack();
    endtask

    task automatic rx_byte(input int ch, input logic [7:0] b);
        @(posedge clk); #1;
        con_istb[ch] = 1'b1;
        if (ch == 0) con_idata[7:0] = b; else con_idata[15:8] = b;
        @(posedge clk); #1;
        con_istb[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = '0; wb_wdata = '0;
        con_busy = '0; con_istb = '0; con_idata = '0;
        idle(3);
        rst = 1'b0;
        idle(1);

        // 1: reset state
        check("rst_console_stb", 32'(con_ostb), 32'h0);
        check("rst_int", 32'(irq), 32'h0);
        check("rst_chan_int", 32'(chan_int), 32'h0);
        check("rst_ack", 32'(wb_ack), 32'h0);
        wb_read("fifo_ch0_rst", 3'b001, 32'h4001_4000);
        wb_read("fifo_ch1_rst", 3'b101, 32'h4001_4000);
        wb_read("setup_ch0_rst", 3'b000, 32'h0);

        // 2: two TX bytes on ch1, first one timed
        txq1.push_back(8'h41);
        rdq.push_back('{chk: 1'b0, want: 32'h0, name: "wr"});
        issue(1'b1, 3'b111, 32'h41);
        @(negedge clk);
        check("tx1_stb_before", 32'(con_ostb[1]), 32'h0);
        @(negedge clk);
        check("tx1_stb_rise", 32'(con_ostb[1]), 32'h1);
        txq1.push_back(8'h42);
        wb_write(3'b111, 32'h42);
        idle(4);
        check("tx0_idle", 32'(con_ostb[0]), 32'h0);
        check("tx1_drained", 32'(con_ostb[1]), 32'h0);
        check("tx1_queue_empty", 32'(txq1.size()), 32'h0);

        // 3: RX overflow on ch0
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            con_istb[0] = 1'b1;
            con_idata[7:0] = 8'(16 + i);
        end
        @(posedge clk); #1;
        con_istb[0] = 1'b0;
        wb_read("fifo_ch0_rxfull", 3'b001, 32'h4001_4043);
        wb_read("rx_first_ovf", 3'b010, 32'h0000_1010);
        for (int i = 1; i < 16; i++)
            wb_read("rx_drain", 3'b010, 32'(16 + i));
        wb_read("rx_empty_last", 3'b010, 32'h0000_011F);

        // 4: RX-not-empty interrupt
        wb_write(3'b000, 32'h1);
        wb_read("setup_ch0_ien", 3'b000, 32'h1);
        rx_byte(0, 8'h55);
        idle(3);
        check("chan_int_set", 32'(chan_int), 32'h1);
        check("int_set", 32'(irq), 32'h1);
        wb_read("rx_byte55", 3'b010, 32'h0000_0055);
        idle(2);
        check("chan_int_clr", 32'(chan_int), 32'h0);
        check("int_clr", 32'(irq), 32'h0);
        wb_read("rx_empty_again", 3'b010, 32'h0000_0155);

        // 5: TX full with simultaneous push and pop
        con_busy[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            txq0.push_back(8'(96 + i));
            wb_write(3'b011, 32'(96 + i));
        end
        wb_read("fifo_ch0_txfull", 3'b001, 32'h4040_4000);
        txq0.push_back(8'h70);
        rdq.push_back('{chk: 1'b0, want: 32'h0, name: "wr"});
        @(posedge clk); #1;
        wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 3'b011; wb_wdata = 32'h70;
        @(posedge clk); #1;
        wb_stb = 1'b0; wb_we = 1'b0; con_busy[0] = 1'b0;
        @(posedge clk); #1;
        con_busy[0] = 1'b1;
        wait_ack();
        wb_read("fifo_ch0_pushpop", 3'b001, 32'h4040_4000);
        wb_read("txreg_ch0_noovf", 3'b011, 32'h0000_0100);
        wb_write(3'b011, 32'h71);
        wb_read("txreg_ch0_ovf", 3'b011, 32'h0000_1100);

        // 6: ch1 reset mid-stream
        con_busy[1] = 1'b1;
        wb_write(3'b111, 32'h81);
        wb_write(3'b111, 32'h82);
        rx_byte(1, 8'h99);
        wb_read("fifo_ch1_before", 3'b101, 32'h400B_4005);
        rdq.push_back('{chk: 1'b0, want: 32'h0, name: "wr"});
        issue(1'b1, 3'b100, 32'h8000_0000);
        @(negedge clk);
        check("ch1_stb_before_rst", 32'(con_ostb[1]), 32'h1);
        @(negedge clk);
        check("ch1_stb_after_rst", 32'(con_ostb[1]), 32'h0);
        wb_read("fifo_ch1_after", 3'b101, 32'h4001_4000);
        wb_read("fifo_ch0_kept", 3'b001, 32'h4040_4000);
        wb_read("txreg_ch1_busy", 3'b111, 32'h0000_0100);
        con_busy[1] = 1'b0;
        wb_read("txreg_ch1_idle", 3'b111, 32'h0);
        con_busy[0] = 1'b0;
        for (int i = 0; i < 100 && txq0.size() != 0; i++)
            idle(1);
        idle(2);
        check("tx0_queue_empty", 32'(txq0.size()), 32'h0);
        check("stb_all_idle", 32'(con_ostb), 32'h0);
        check("rd_queue_empty", 32'(rdq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
